// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared types and constants for the pipeline hazard sequencer.
//   - creg_addr_t  : architectural register index (x0..x31)
//   - REG_ZERO     : the hard-wired zero register, never a hazard source
//   - stage_ctl_t  : hold / bubble pair for one pipeline register
//   - ctl_state_e  : sequencer state (normal running / discarding a stale fetch)
//   - ctl_act_e    : the single action chosen by the priority mux each cycle
//   - reg_match()  : true when a source register really depends on a destination
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_W = 5;
    localparam int PC_W  = 64;

    typedef logic [REG_W-1:0] creg_addr_t;

    localparam creg_addr_t REG_ZERO = '0;

    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctl_t;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } ctl_state_e;

    // One action per cycle; the order of the encodings carries no meaning,
    // the priority lives in hazard_ctrl.
    typedef enum logic [2:0] {
        ACT_NONE   = 3'd0,
        ACT_DBUSY  = 3'd1,
        ACT_IFETCH = 3'd2,
        ACT_HAZARD = 3'd3,
        ACT_JUMP   = 3'd4,
        ACT_DROP   = 3'd5
    } ctl_act_e;

    // Writes to x0 are discarded, so a match on x0 is never a dependency.
    function automatic logic reg_match(input creg_addr_t src, input creg_addr_t dst);
        return (dst != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
//   Pure combinational detection of the two data hazards the sequencer must
//   resolve by stalling decode:
//     lu : load-use   - D reads a register that the load in E has not fetched yet
//     bo : branch-op  - a D-stage branch/JALR needs an operand that is either
//                       still being computed in E or still being loaded in M
//                       (branches compare in D, so E->D and load-M->D forwarding
//                       is not available to them)
//
// Ports
//   ra1, ra2      in  D-stage source registers
//   use1, use2    in  D instruction actually reads ra1 / ra2
//   d_branch      in  D instruction resolves in D and needs both operands
//   e_memread     in  E instruction is a load
//   e_regwrite    in  E instruction writes a register
//   e_dst         in  E destination register
//   m_memread     in  M instruction is a load
//   m_dst         in  M destination register
//   lu            out load-use hazard
//   bo            out branch-operand hazard
// -----------------------------------------------------------------------------
module hazard_detect
    import hazard_pkg::*;
(
    input  creg_addr_t ra1,
    input  creg_addr_t ra2,
    input  logic       use1,
    input  logic       use2,
    input  logic       d_branch,
    input  logic       e_memread,
    input  logic       e_regwrite,
    input  creg_addr_t e_dst,
    input  logic       m_memread,
    input  creg_addr_t m_dst,
    output logic       lu,
    output logic       bo
);

    logic e_hit1;
    logic e_hit2;
    logic m_hit1;
    logic m_hit2;

    assign e_hit1 = reg_match(ra1, e_dst);
    assign e_hit2 = reg_match(ra2, e_dst);
    assign m_hit1 = reg_match(ra1, m_dst);
    assign m_hit2 = reg_match(ra2, m_dst);

    // Load-use only matters for operands the instruction really reads.
    assign lu = e_memread & ((use1 & e_hit1) | (use2 & e_hit2));

    // Branches are conservative: either operand field matching is enough.
    assign bo = d_branch & ((e_regwrite & (e_hit1 | e_hit2))
                          | (m_memread  & (m_hit1 | m_hit2)));

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Central sequencer for the 5-stage pipeline. Each cycle it picks exactly one
//   action from (highest first): data-bus wait, instruction-fetch wait, data
//   hazard, taken jump. A taken jump while a fetch is still outstanding moves
//   the sequencer into DROP, where fetch is held and decode is bubbled until
//   the stale response arrives and is discarded.
//   A saturating counter reports the number of cycles fetch was stalled.
//
// Parameters
//   CNT_W        width of stall_cnt; the counter saturates at all-ones
//
// Ports
//   clk          core clock
//   reset        asynchronous, active-high
//   ra1, ra2     D-stage source registers; use1/use2 qualify them
//   d_branch     D instruction needs its operands in D
//   jump_d       D resolved a taken branch/jump to pcsrc_d
//   e_*, m_*     producer information from E and M
//   i_busy       fetch request outstanding
//   i_data_ok    fetch response this cycle
//   d_busy       M-stage data request outstanding
//   stallF..M    hold the corresponding stage register
//   flushD/E/W   load a bubble into the corresponding stage register
//   redirect     one-cycle pulse: load PC with redirect_pc
//   redirect_pc  jump target; holds the last target between jumps
//   drop_fetch   discard the instruction returned with i_data_ok
//   stall_cnt    cycles with stallF=1 (saturating)
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  creg_addr_t       ra1,
    input  creg_addr_t       ra2,
    input  logic             use1,
    input  logic             use2,
    input  logic             d_branch,
    input  logic             jump_d,
    input  logic [PC_W-1:0]  pcsrc_d,
    input  logic             e_memread,
    input  logic             e_regwrite,
    input  creg_addr_t       e_dst,
    input  logic             m_memread,
    input  creg_addr_t       m_dst,
    input  logic             i_busy,
    input  logic             i_data_ok,
    input  logic             d_busy,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             drop_fetch,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic lu;
    logic bo;

    hazard_detect u_detect (
        .ra1        (ra1),
        .ra2        (ra2),
        .use1       (use1),
        .use2       (use2),
        .d_branch   (d_branch),
        .e_memread  (e_memread),
        .e_regwrite (e_regwrite),
        .e_dst      (e_dst),
        .m_memread  (m_memread),
        .m_dst      (m_dst),
        .lu         (lu),
        .bo         (bo)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ctl_state_e        state_q;
    ctl_state_e        state_d;
    ctl_act_e          act;
    logic [PC_W-1:0]   redirect_pc_q;
    logic [PC_W-1:0]   redirect_pc_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    // Raw (pre-reset-gating) control decisions.
    stage_ctl_t ctl_d;
    stage_ctl_t ctl_e;
    logic       stall_f;
    logic       stall_m;
    logic       flush_w;
    logic       redirect_raw;
    logic       drop_raw;

    // ------------------------------------------------------------------
    // Priority mux: exactly one action per cycle.
    // A data-bus wait freezes everything, including a pending jump, because
    // the jump is simply re-presented once the pipeline moves again.
    // In DROP decode holds a bubble, so neither hazards nor jumps can occur.
    // A jump is ignored under a data hazard because its operands are stale.
    // ------------------------------------------------------------------
    // NOTE: every combinational block assigns a default first so that no
    // path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        act = ACT_NONE;
        if (d_busy) begin
            act = ACT_DBUSY;
        end else if (state_q == DROP) begin
            act = ACT_DROP;
        end else if (i_busy && !jump_d) begin
            act = ACT_IFETCH;
        end else if (lu || bo) begin
            act = ACT_HAZARD;
        end else if (jump_d) begin
            act = ACT_JUMP;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // its pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next state
    // A jump taken while the fetch of the sequential instruction is still in
    // flight must discard that response when it finally arrives. If the
    // response arrives in the jump cycle itself, flushD already kills it.
    // The DROP exit is independent of d_busy: the fetch response is consumed
    // (and discarded) whatever the data side is doing.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (act == ACT_JUMP && i_busy && !i_data_ok) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (i_data_ok) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ctl_d        = '0;
        ctl_e        = '0;
        stall_f      = 1'b0;
        stall_m      = 1'b0;
        flush_w      = 1'b0;
        redirect_raw = 1'b0;

        unique case (act)
            ACT_DBUSY: begin
                // M cannot retire: hold F..M and send a bubble to W.
                stall_f     = 1'b1;
                ctl_d.stall = 1'b1;
                ctl_e.stall = 1'b1;
                stall_m     = 1'b1;
                flush_w     = 1'b1;
            end
            ACT_IFETCH, ACT_HAZARD: begin
                // Hold the front end and let E drain with a bubble.
                stall_f     = 1'b1;
                ctl_d.stall = 1'b1;
                ctl_e.flush = 1'b1;
            end
            ACT_JUMP: begin
                // The instruction behind the jump is on the wrong path.
                redirect_raw = 1'b1;
                ctl_d.flush  = 1'b1;
            end
            ACT_DROP: begin
                // PC is already redirected; wait for the stale response.
                stall_f     = 1'b1;
                ctl_d.flush = 1'b1;
            end
            default: ;
        endcase

        drop_raw = (state_q == DROP) && i_data_ok;
    end

    // Outputs are forced low while reset is asserted, so an asynchronous
    // reset in the middle of a cycle quiets the pipeline immediately.
    assign stallF     = ~reset & stall_f;
    assign stallD     = ~reset & ctl_d.stall;
    assign stallE     = ~reset & ctl_e.stall;
    assign stallM     = ~reset & stall_m;
    assign flushD     = ~reset & ctl_d.flush;
    assign flushE     = ~reset & ctl_e.flush;
    assign flushW     = ~reset & flush_w;
    assign redirect   = ~reset & redirect_raw;
    assign drop_fetch = ~reset & drop_raw;

    // ------------------------------------------------------------------
    // Redirect target: presented straight through in the jump cycle and
    // held afterwards, so fetch sees a stable value while it is stalled.
    // ------------------------------------------------------------------
    assign redirect_pc_d = redirect ? pcsrc_d : redirect_pc_q;
    assign redirect_pc   = redirect_pc_d;

    // ------------------------------------------------------------------
    // Stall-cycle counter: saturates instead of wrapping so long runs read
    // as "at least this many" rather than a small bogus number.
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stallF && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_pc_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            redirect_pc_q <= redirect_pc_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl. Single-cycle behaviour (all from RUN) is a
//   table of {inputs, expected controls}; multi-cycle behaviour (stalled jump,
//   DROP sequence, bus wait, counter saturation, reset in DROP) is hand-written.
//   A second instance with CNT_W=4 shares every input to exercise saturation.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    // Expected control vector bit order:
    // {stallF, stallD, stallE, stallM, flushD, flushE, flushW, redirect, drop_fetch}
    localparam logic [8:0] X_NONE   = 9'b000000000;
    localparam logic [8:0] X_STALL  = 9'b110001000;
    localparam logic [8:0] X_DBUSY  = 9'b111100100;
    localparam logic [8:0] X_JUMP   = 9'b000010010;
    localparam logic [8:0] X_DROP   = 9'b100010000;
    localparam logic [8:0] X_DROPOK = 9'b100010001;

    typedef struct {
        string       name;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        use1;
        logic        use2;
        logic        d_branch;
        logic        jump_d;
        logic [63:0] pcsrc;
        logic        e_memread;
        logic        e_regwrite;
        logic [4:0]  e_dst;
        logic        m_memread;
        logic [4:0]  m_dst;
        logic        i_busy;
        logic        i_data_ok;
        logic        d_busy;
        logic [8:0]  exp;
    } vec_t;

    localparam int NVEC = 20;

    logic        clk;
    logic        reset;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        use1;
    logic        use2;
    logic        d_branch;
    logic        jump_d;
    logic [63:0] pcsrc_d;
    logic        e_memread;
    logic        e_regwrite;
    logic [4:0]  e_dst;
    logic        m_memread;
    logic [4:0]  m_dst;
    logic        i_busy;
    logic        i_data_ok;
    logic        d_busy;

    logic        stallF, stallD, stallE, stallM;
    logic        flushD, flushE, flushW;
    logic        redirect, drop_fetch;
    logic [63:0] redirect_pc;
    logic [31:0] stall_cnt;

    logic        s4_stallF, s4_stallD, s4_stallE, s4_stallM;
    logic        s4_flushD, s4_flushE, s4_flushW;
    logic        s4_redirect, s4_drop_fetch;
    logic [63:0] s4_redirect_pc;
    logic [3:0]  s4_stall_cnt;

    logic [8:0]  outs;
    assign outs = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, redirect, drop_fetch};

    int n_chk = 0;
    int n_err = 0;

    hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .ra1(ra1), .ra2(ra2), .use1(use1), .use2(use2),
        .d_branch(d_branch), .jump_d(jump_d), .pcsrc_d(pcsrc_d),
        .e_memread(e_memread), .e_regwrite(e_regwrite), .e_dst(e_dst),
        .m_memread(m_memread), .m_dst(m_dst),
        .i_busy(i_busy), .i_data_ok(i_data_ok), .d_busy(d_busy),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .drop_fetch(drop_fetch), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .ra1(ra1), .ra2(ra2), .use1(use1), .use2(use2),
        .d_branch(d_branch), .jump_d(jump_d), .pcsrc_d(pcsrc_d),
        .e_memread(e_memread), .e_regwrite(e_regwrite), .e_dst(e_dst),
        .m_memread(m_memread), .m_dst(m_dst),
        .i_busy(i_busy), .i_data_ok(i_data_ok), .d_busy(d_busy),
        .stallF(s4_stallF), .stallD(s4_stallD), .stallE(s4_stallE), .stallM(s4_stallM),
        .flushD(s4_flushD), .flushE(s4_flushE), .flushW(s4_flushW),
        .redirect(s4_redirect), .redirect_pc(s4_redirect_pc),
        .drop_fetch(s4_drop_fetch), .stall_cnt(s4_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic idle_inputs();
        ra1 = 5'd0; ra2 = 5'd0; use1 = 1'b0; use2 = 1'b0;
        d_branch = 1'b0; jump_d = 1'b0; pcsrc_d = 64'd0;
        e_memread = 1'b0; e_regwrite = 1'b0; e_dst = 5'd0;
        m_memread = 1'b0; m_dst = 5'd0;
        i_busy = 1'b0; i_data_ok = 1'b0; d_busy = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        ra1 = v.ra1; ra2 = v.ra2; use1 = v.use1; use2 = v.use2;
        d_branch = v.d_branch; jump_d = v.jump_d; pcsrc_d = v.pcsrc;
        e_memread = v.e_memread; e_regwrite = v.e_regwrite; e_dst = v.e_dst;
        m_memread = v.m_memread; m_dst = v.m_dst;
        i_busy = v.i_busy; i_data_ok = v.i_data_ok; d_busy = v.d_busy;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse asserted right after a rising edge, released on a falling edge.
    task automatic pulse_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        next_cycle();
    endtask

    vec_t        vecs [NVEC];
    logic [63:0] last_pc;
    logic [63:0] exp_pc;
    int          exp_cnt;

    initial begin
        //                name           ra1    ra2    u1    u2    br    jmp   pcsrc                  em    ew    ed     mm    md     ib    iok   db    exp
        vecs[0]  = '{"idle",        5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, X_NONE};
        vecs[1]  = '{"lu_ra1",      5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, X_STALL};
        vecs[2]  = '{"lu_ra2",      5'd0,  5'd9,  1'b0, 1'b1, 1'b0, 1'b0, 64'h0,                 1'b1, 1'b1, 5'd9,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, X_STALL};
        vecs[3]  = '{"lu_unused",   5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, X_NONE};
        vecs[4]  = '{"lu_x0",       5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 64'h0,                 1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, X_NONE};
        vecs[5]  = '{"bo_e_jump",   5'd0,  5'd7,  1'b0, 1'b1, 1'b1, 1'b1, 64'h1234,              1'b0, 1'b1, 5'd7,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, X_STALL};
        vecs[6]  = '{"bo_m_load",   5'd3,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 64'h0,                 1'b0, 1'b0, 5'd0,  1'b1, 5'd3,  1'b0, 1'b0, 1'b0, X_STALL};
        vecs[7]  = '{"bo_m_x0",     5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 64'h0,                 1'b0, 1'b0, 5'd0,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, X_NONE};
        vecs[8]  = '{"alu_fwd",     5'd4,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                 1'b0, 1'b1, 5'd4,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, X_NONE};
        vecs[9]  = '{"jump",        5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0040,         1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, X_JUMP};
        vecs[10] = '{"jump_dataok", 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_0001_0000_0100, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, X_JUMP};
        vecs[11] = '{"no_drop",     5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, X_NONE};
        vecs[12] = '{"ifetch",      5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, X_STALL};
        vecs[13] = '{"ifetch_lu",   5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 1'b1, 5'd5,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, X_STALL};
        vecs[14] = '{"dbusy",       5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1, X_DBUSY};
        vecs[15] = '{"dbusy_jump",  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 64'hdead,              1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1, X_DBUSY};
        vecs[16] = '{"dbusy_all",   5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 1'b1, 5'd5,  1'b0, 5'd0,  1'b1, 1'b0, 1'b1, X_DBUSY};
        vecs[17] = '{"jump_lu",     5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 64'hbeef,              1'b1, 1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, X_STALL};
        vecs[18] = '{"dataok_run",  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, X_NONE};
        vecs[19] = '{"bo_e_ra1",    5'd6,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 64'h0,                 1'b1, 1'b1, 5'd6,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, X_STALL};

        // ---------------- reset state (busy inputs present) ----------------
        reset = 1'b1;
        idle_inputs();
        d_busy  = 1'b1;
        jump_d  = 1'b1;
        pcsrc_d = 64'h55;
        #3;
        check("reset_ctl", 64'(outs), 64'(X_NONE));
        check("reset_pc", redirect_pc, 64'h0);
        check("reset_cnt", 64'(stall_cnt), 64'h0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        next_cycle();

        // ---------------- single-cycle table from RUN ----------------
        last_pc = 64'h0;
        exp_cnt = 0;
        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i]);
            @(negedge clk);
            check({vecs[i].name, "_ctl"}, 64'(outs), 64'(vecs[i].exp));
            exp_pc = vecs[i].exp[1] ? vecs[i].pcsrc : last_pc;
            check({vecs[i].name, "_pc"}, redirect_pc, exp_pc);
            last_pc = exp_pc;
            if (vecs[i].exp[8]) exp_cnt++;
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        check("table_cnt", 64'(stall_cnt), 64'(exp_cnt));
        check("table_cnt4", 64'(s4_stall_cnt), 64'((exp_cnt > 15) ? 15 : exp_cnt));
        next_cycle();

        // ---------------- branch operand hazard, then jump ----------------
        d_branch = 1'b1; ra2 = 5'd7; use2 = 1'b1;
        e_regwrite = 1'b1; e_dst = 5'd7;
        jump_d = 1'b1; pcsrc_d = 64'h2000;
        @(negedge clk);
        check("bo_jump_stall", 64'(outs), 64'(X_STALL));
        next_cycle();
        e_regwrite = 1'b0; e_dst = 5'd0;
        @(negedge clk);
        check("bo_jump_go", 64'(outs), 64'(X_JUMP));
        check("bo_jump_pc", redirect_pc, 64'h2000);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("bo_jump_after", 64'(outs), 64'(X_NONE));
        check("bo_jump_pc_hold", redirect_pc, 64'h2000);
        next_cycle();

        // ---------------- jump with outstanding fetch -> DROP ----------------
        jump_d = 1'b1; pcsrc_d = 64'h8000_0040; i_busy = 1'b1;
        @(negedge clk);
        check("drop_jump", 64'(outs), 64'(X_JUMP));
        check("drop_jump_pc", redirect_pc, 64'h8000_0040);
        next_cycle();
        jump_d = 1'b0; pcsrc_d = 64'h0;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin
                i_busy = 1'b0;
                i_data_ok = 1'b1;
            end
            @(negedge clk);
            check($sformatf("drop_cyc%0d", k), 64'(outs), 64'((k == 3) ? X_DROPOK : X_DROP));
            check($sformatf("drop_pc%0d", k), redirect_pc, 64'h8000_0040);
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        check("drop_back_run", 64'(outs), 64'(X_NONE));
        next_cycle();

        // ---------------- data-bus wait over a load-use ----------------
        pulse_reset();
        ra1 = 5'd5; use1 = 1'b1; e_memread = 1'b1; e_regwrite = 1'b1; e_dst = 5'd5;
        d_busy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("dbusy_cyc%0d", k), 64'(outs), 64'(X_DBUSY));
            next_cycle();
        end
        d_busy = 1'b0;
        @(negedge clk);
        check("dbusy_then_lu", 64'(outs), 64'(X_STALL));
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("dbusy_idle", 64'(outs), 64'(X_NONE));
        check("dbusy_cnt", 64'(stall_cnt), 64'd5);
        next_cycle();

        // ---------------- counter saturation ----------------
        pulse_reset();
        i_busy = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            next_cycle();
            if (c == 14) check("sat_cnt4_14", 64'(s4_stall_cnt), 64'd14);
            if (c == 15) check("sat_cnt4_15", 64'(s4_stall_cnt), 64'd15);
        end
        check("sat_cnt4_20", 64'(s4_stall_cnt), 64'd15);
        check("sat_cnt32_20", 64'(stall_cnt), 64'd20);
        idle_inputs();
        next_cycle();

        // ---------------- async reset in the middle of DROP ----------------
        jump_d = 1'b1; pcsrc_d = 64'h4000; i_busy = 1'b1;
        next_cycle();
        jump_d = 1'b0; pcsrc_d = 64'h0;
        @(negedge clk);
        check("rst_drop_before", 64'(outs), 64'(X_DROP));
        #2;
        reset = 1'b1;
        #1;
        check("rst_drop_ctl", 64'(outs), 64'(X_NONE));
        check("rst_drop_pc", redirect_pc, 64'h0);
        check("rst_drop_cnt", 64'(stall_cnt), 64'h0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        next_cycle();
        @(negedge clk);
        check("rst_drop_run", 64'(outs), 64'(X_NONE));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
